iq_capture_buffer: RTL

IQ_CAPTURE_BUFFER -- requirements
Module: iq_capture_buffer

---
 rtl/iq_capture_buffer_if.sv | 36 +++
 rtl/iq_capture_buffer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/iq_capture_buffer_if.sv
// Signal bundle for iq_capture_buffer: arm/length control, filtered sample stream,
// DAC output stream, capture read port and status flags.
interface iq_capture_buffer_if #(
    parameter int IN_W       = 12,
    parameter int OUT_W      = 10,
    parameter int HEAD_DEPTH = 64,
    parameter int TAIL_DEPTH = 64,
    parameter int LEN_W      = 16,
    parameter int ADDR_W     = $clog2(2*(HEAD_DEPTH+TAIL_DEPTH))
);
    logic                    arm;
    logic [LEN_W-1:0]        pkt_len;
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_i;
    logic signed [IN_W-1:0]  in_q;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_i;
    logic signed [OUT_W-1:0] out_q;
    logic                    rd_req;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    rd_ack;
    logic signed [IN_W-1:0]  rd_data;
    logic                    busy;
    logic                    done;
    logic                    len_err;

    modport master (
        output arm, pkt_len, in_valid, in_i, in_q, rd_req, rd_addr,
        input  out_valid, out_i, out_q, rd_ack, rd_data, busy, done, len_err
    );

    modport slave (
        input  arm, pkt_len, in_valid, in_i, in_q, rd_req, rd_addr,
        output out_valid, out_i, out_q, rd_ack, rd_data, busy, done, len_err
    );
endinterface

// File: rtl/iq_capture_buffer.sv
// IQ capture buffer: 1-cycle DAC conversion path plus head/tail packet capture with read port.
// Define IQ_CAPTURE_ROUND_EN for round-half-up with saturation; default build truncates.
module iq_capture_buffer #(
    parameter int IN_W       = 12,
    parameter int OUT_W      = 10,
    parameter int HEAD_DEPTH = 64,
    parameter int TAIL_DEPTH = 64,
    parameter int LEN_W      = 16,
    parameter int ADDR_W     = $clog2(2*(HEAD_DEPTH+TAIL_DEPTH))
) (
    input  logic              clk,
    input  logic              rst,
    iq_capture_buffer_if.slave bus
);
    localparam int SHIFT  = IN_W - OUT_W;
    localparam int TP_W   = $clog2(TAIL_DEPTH);
    localparam int HP_W   = $clog2(HEAD_DEPTH);
    localparam int SLOT_W = ADDR_W - 1;
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(HEAD_DEPTH + TAIL_DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

`ifdef IQ_CAPTURE_ROUND_EN
    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MINV = -MAXV - (IN_W+1)'(1);

    function automatic logic signed [OUT_W-1:0] conv(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] shr;
        sum = {x[IN_W-1], x} + HALF;
        shr = sum >>> SHIFT;
        if (shr > MAXV)      return MAXV[OUT_W-1:0];
        else if (shr < MINV) return MINV[OUT_W-1:0];
        else                 return shr[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] conv(input logic signed [IN_W-1:0] x);
        return x[IN_W-1:SHIFT];
    endfunction
`endif

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        cnt_q, len_q;
    logic [TP_W-1:0]         tp_q;
    logic                    len_err_q;
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_i_q, out_q_q;
    logic                    rd_ack_q;
    logic signed [IN_W-1:0]  rd_data_q;
    logic                    accept, reject, wr_en;

    logic signed [IN_W-1:0]  head_i_mem [HEAD_DEPTH];
    logic signed [IN_W-1:0]  head_q_mem [HEAD_DEPTH];
    logic signed [IN_W-1:0]  ring_i_mem [TAIL_DEPTH];
    logic signed [IN_W-1:0]  ring_q_mem [TAIL_DEPTH];

    logic [SLOT_W-1:0]       slot;
    logic [TP_W-1:0]         ridx;
    logic signed [IN_W-1:0]  rd_sample;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.arm) begin
                    if (bus.pkt_len >= MIN_LEN) begin
                        accept  = 1'b1;
                        state_d = CAPTURE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                // arm is deliberately not looked at here
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == len_q - 1'b1) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            tp_q        <= '0;
            len_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                len_q     <= bus.pkt_len;
                cnt_q     <= '0;
                tp_q      <= '0;
                len_err_q <= 1'b0;
            end else if (reject) begin
                len_err_q <= 1'b1;
            end
            if (wr_en) begin
                cnt_q <= cnt_q + 1'b1;
                tp_q  <= tp_q + 1'b1;
            end
            out_valid_q <= bus.in_valid;
            out_i_q     <= bus.in_valid ? conv(bus.in_i) : '0;
            out_q_q     <= bus.in_valid ? conv(bus.in_q) : '0;
            rd_ack_q    <= bus.rd_req;
            if (bus.rd_req) rd_data_q <= (state_q == DONE) ? rd_sample : '0;
        end
    end

    // Sample storage is never reset; reads are gated to 0 outside DONE instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (cnt_q < LEN_W'(HEAD_DEPTH)) begin
                head_i_mem[HP_W'(cnt_q)] <= bus.in_i;
                head_q_mem[HP_W'(cnt_q)] <= bus.in_q;
            end
            ring_i_mem[tp_q] <= bus.in_i;
            ring_q_mem[tp_q] <= bus.in_q;
        end
    end

    // Tail slot 0 is the oldest entry, which sits at the current ring write pointer.
    always_comb begin
        slot      = bus.rd_addr[ADDR_W-1:1];
        ridx      = tp_q + TP_W'(slot - SLOT_W'(HEAD_DEPTH));
        rd_sample = '0;
        if (slot < SLOT_W'(HEAD_DEPTH))
            rd_sample = bus.rd_addr[0] ? head_q_mem[HP_W'(slot)] : head_i_mem[HP_W'(slot)];
        else
            rd_sample = bus.rd_addr[0] ? ring_q_mem[ridx] : ring_i_mem[ridx];
    end

    assign bus.busy      = (state_q == CAPTURE);
    assign bus.done      = (state_q == DONE);
    assign bus.len_err   = len_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_i     = out_i_q;
    assign bus.out_q     = out_q_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.rd_data   = rd_data_q;
endmodule
